system_0_sysid_checker: RTL

//  Boot-time Avalon-MM master that reads the system ID slave (address 0 = system ID,

---
 rtl/system_0_sysid_checker_pkg.sv | 14 +
 rtl/system_0_sysid_checker_timer.sv | 38 +++
 rtl/system_0_sysid_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/system_0_sysid_checker_pkg.sv
// Shared types for the sysid checker: FSM states, sysid word addresses, counter sizing.
package system_0_sysid_checker_pkg;

  typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Wide enough for the stall limit and for the largest read latency (3).
  function automatic int cnt_width(input int timeout_cycles);
    return ($clog2(timeout_cycles + 1) < 2) ? 2 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/system_0_sysid_checker_timer.sv
// Loadable up/down counter used for both read-latency countdown and waitrequest stall counting.
// Load wins over inc, and inc wins over dec; the count updates one cycle after the request.
module system_0_sysid_checker_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end else if (dec) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/system_0_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp over Avalon-MM, flags pass/fail/timeout (SYSID_CHECK_AUTOSTART_EN adds a start after reset).
// done 3 cycles after start at READ_LATENCY=0 with no stall; waitrequest stalls each read, bounded by TIMEOUT_CYCLES.
module system_0_sysid_checker
  import system_0_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1563219222,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        sys_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAT_LOAD    = (READ_LATENCY > 0) ? CW'(READ_LATENCY - 1) : '0;
  localparam logic [CW-1:0] STALL_LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_e        state_q, state_d;
  logic          addr_q, addr_d;
  logic [31:0]   id_value_q, id_value_d;
  logic [31:0]   ts_value_q, ts_value_d;
  logic          id_ok_q, id_ok_d;
  logic          ts_ok_q, ts_ok_d;
  logic          timeout_q, timeout_d;
  logic          tmr_load, tmr_inc, tmr_dec, capture;
  logic [CW-1:0] tmr_val, tmr_count;
  logic          start_int;

`ifdef SYSID_CHECK_AUTOSTART_EN
  // Armed by reset; fires a single internal start on the first clock after release.
  logic auto_arm_q, auto_arm_d, auto_start_q, auto_start_d;

  always_comb begin
    auto_arm_d   = 1'b0;
    auto_start_d = auto_arm_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_arm_q   <= 1'b1;
      auto_start_q <= 1'b0;
    end else begin
      auto_arm_q   <= auto_arm_d;
      auto_start_q <= auto_start_d;
    end
  end

  assign start_int = start | auto_start_q;
`else
  assign start_int = start;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_inc    = 1'b0;
    tmr_dec    = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_int) begin
          state_d   = REQ;
          addr_d    = ADDR_ID;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      REQ: begin
        if (avm_waitrequest) begin
          if ((TIMEOUT_CYCLES != 0) && (tmr_count == STALL_LIMIT)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
          end else begin
            tmr_inc = (TIMEOUT_CYCLES != 0);
          end
        end else if (READ_LATENCY > 0) begin
          state_d  = LAT;
          tmr_load = 1'b1;
          tmr_val  = LAT_LOAD;
        end else begin
          capture = 1'b1;
        end
      end
      LAT: begin
        if (tmr_count == '0) begin
          capture = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word 0 chains straight into the timestamp read; word 1 registers both compares.
    if (capture) begin
      if (addr_q == ADDR_ID) begin
        id_value_d = avm_readdata;
        addr_d     = ADDR_TS;
        state_d    = REQ;
        tmr_load   = 1'b1;
      end else begin
        ts_value_d = avm_readdata;
        id_ok_d    = (id_value_q == EXPECTED_ID);
        ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
        state_d    = DONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= ADDR_ID;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
    end
  end

  system_0_sysid_checker_timer #(.W(CW)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .inc      (tmr_inc),
    .dec      (tmr_dec),
    .count    (tmr_count)
  );

  assign avm_address = addr_q;
  assign avm_read    = (state_q == REQ);
  assign busy        = (state_q == REQ) || (state_q == LAT);
  assign done        = (state_q == DONE);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign sys_ok      = id_ok_q & ts_ok_q & ~timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
